// File: rtl/bus_fabric.sv
// N-port memory interconnect: per-port RAM/ROM/IO decode with registered read muxing,
// a shared debug-output FIFO, sticky completion tracking and a ROM-write error counter.
module bus_fabric #(
    parameter int          NPORTS     = 2,
    parameter int          RAM_AW     = 14,
    parameter int          ROM_AW     = 15,
    parameter logic [15:0] DPORT_ADDR = 16'h4000,
    parameter logic [15:0] DONE_ADDR  = 16'h4100,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [16*NPORTS-1:0]     addr_i,
    input  logic [8*NPORTS-1:0]      wdata_i,
    input  logic [NPORTS-1:0]        we_i,
    output logic [8*NPORTS-1:0]      rdata_o,
    output logic [NPORTS-1:0]        ram_we_o,
    output logic [RAM_AW*NPORTS-1:0] ram_addr_o,
    output logic [8*NPORTS-1:0]      ram_wdata_o,
    input  logic [8*NPORTS-1:0]      ram_rdata_i,
    output logic [ROM_AW*NPORTS-1:0] rom_addr_o,
    input  logic [8*NPORTS-1:0]      rom_rdata_i,
    output logic [7:0]               dport_data_o,
    output logic                     dport_valid_o,
    input  logic                     dport_ready_i,
    output logic                     dport_overflow_o,
    output logic                     done_o,
    output logic [7:0]               err_count_o
);

    localparam int          PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CW        = PW + 1;
    localparam int          NW        = $clog2(NPORTS + 1);
    localparam logic [16:0] RAM_LIMIT = 17'(2 ** RAM_AW);
    localparam logic [16:0] ROM_BASE  = 17'(65536 - 2 ** ROM_AW);

    logic [NPORTS-1:0] csRam, csRom, csRam_q, csRom_q;
    logic [NPORTS-1:0] pushReq, doneReq, romWr, pushAcc;
    logic [NPORTS-1:0] doneFlags_q;
    logic [7:0]        fifoMem [FIFO_DEPTH];
    logic [PW-1:0]     wrPtr_q, rdPtr_q;
    logic [PW-1:0]     pushIdx [NPORTS];
    logic [CW-1:0]     count_q, freeSlots, accCount;
    logic              overflow_q, dropped, pop;
    logic [NW-1:0]     romCount;
    logic [8:0]        errSum;
    logic [7:0]        errCount_q, errCount_d;

    genvar g;
    for (g = 0; g < NPORTS; g++) begin : g_port
        logic [15:0] portAddr;
        assign portAddr    = addr_i[g*16 +: 16];
        assign csRam[g]    = {1'b0, portAddr} < RAM_LIMIT;
        assign csRom[g]    = {1'b0, portAddr} >= ROM_BASE;
        assign pushReq[g]  = we_i[g] && (portAddr == DPORT_ADDR);
        assign doneReq[g]  = we_i[g] && (portAddr == DONE_ADDR);
        assign romWr[g]    = we_i[g] && csRom[g];
        assign ram_addr_o[g*RAM_AW +: RAM_AW] = portAddr[RAM_AW-1:0];
        assign rom_addr_o[g*ROM_AW +: ROM_AW] = portAddr[ROM_AW-1:0];
        assign rdata_o[g*8 +: 8] = csRam_q[g] ? ram_rdata_i[g*8 +: 8] :
                                   csRom_q[g] ? rom_rdata_i[g*8 +: 8] : 8'h00;
    end

    assign ram_we_o         = we_i & csRam;
    assign ram_wdata_o      = wdata_i;
    assign dport_valid_o    = (count_q != '0);
    assign dport_data_o     = dport_valid_o ? fifoMem[rdPtr_q] : 8'h00;
    assign dport_overflow_o = overflow_q;
    assign done_o           = &doneFlags_q;
    assign err_count_o      = errCount_q;
    assign pop              = dport_valid_o && dport_ready_i;

    // Space is judged against the occupancy at the start of the cycle, so a pop never
    // makes room for pushes in the same cycle; lower port indices win the free slots.
    always_comb begin
        freeSlots = CW'(FIFO_DEPTH) - count_q;
        accCount  = '0;
        pushAcc   = '0;
        dropped   = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            pushIdx[p] = wrPtr_q + accCount[PW-1:0];
            if (pushReq[p]) begin
                if (accCount < freeSlots) begin
                    pushAcc[p] = 1'b1;
                    accCount   = accCount + CW'(1);
                end else begin
                    dropped = 1'b1;
                end
            end
        end
    end

    always_comb begin
        romCount = '0;
        for (int p = 0; p < NPORTS; p++) begin
            romCount = romCount + NW'(romWr[p]);
        end
        errSum     = {1'b0, errCount_q} + 9'(romCount);
        errCount_d = (errSum > 9'd255) ? 8'hFF : errSum[7:0];
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORTS; p++) begin
            if (pushAcc[p] && !rst) begin
                fifoMem[pushIdx[p]] <= wdata_i[p*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csRam_q     <= '0;
            csRom_q     <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            doneFlags_q <= '0;
            errCount_q  <= 8'h00;
        end else begin
            csRam_q     <= csRam;
            csRom_q     <= csRom;
            wrPtr_q     <= wrPtr_q + accCount[PW-1:0];
            rdPtr_q     <= rdPtr_q + PW'(pop);
            count_q     <= count_q + accCount - CW'(pop);
            overflow_q  <= overflow_q | dropped;
            doneFlags_q <= doneFlags_q | doneReq;
            errCount_q  <= errCount_d;
        end
    end

endmodule

// File: tb/tb_bus_fabric.sv
// Self-checking bench for bus_fabric: a queue/array reference model is advanced
// alongside the DUT each cycle and each scenario task compares outputs against it.
module tb_bus_fabric;

    localparam int NP    = 2;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [1:0]  we;
    logic [15:0] rdata;
    logic [1:0]  ram_we;
    logic [27:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic [29:0] rom_addr;
    logic [15:0] rom_rdata;
    logic [7:0]  dport_data;
    logic        dport_valid;
    logic        dport_ready;
    logic        dport_overflow;
    logic        done;
    logic [7:0]  err_count;

    int checks   = 0;
    int failures = 0;

    byte unsigned mdlQ[$];
    bit           mdlOvf;
    bit [1:0]     mdlDone;
    int           mdlErr;
    int           prevRegion[NP];
    logic [7:0]   expRdata[NP];

    bus_fabric dut (
        .clk(clk), .rst(rst),
        .addr_i(addr), .wdata_i(wdata), .we_i(we), .rdata_o(rdata),
        .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
        .ram_rdata_i(ram_rdata), .rom_addr_o(rom_addr), .rom_rdata_i(rom_rdata),
        .dport_data_o(dport_data), .dport_valid_o(dport_valid),
        .dport_ready_i(dport_ready), .dport_overflow_o(dport_overflow),
        .done_o(done), .err_count_o(err_count)
    );

    always #5 clk = ~clk;

    // 0 = IO, 1 = RAM (below 16 KiB), 2 = ROM (top 32 KiB)
    function automatic int region(input logic [15:0] a);
        if (int'(a) < 16384) return 1;
        if (int'(a) >= 65536 - 32768) return 2;
        return 0;
    endfunction

    function automatic logic [1:0] expRamWe();
        logic [1:0] r;
        for (int p = 0; p < NP; p++) r[p] = we[p] && (region(addr[p*16 +: 16]) == 1);
        return r;
    endfunction

    // Advance the reference model by one clock using the currently driven inputs,
    // then clock the DUT and present fresh random memory read data.
    task automatic step();
        int free, acc, nRom;
        byte unsigned tmp;
        logic [15:0] a;
        if (rst) begin
            mdlQ.delete();
            mdlOvf  = 0;
            mdlDone = '0;
            mdlErr  = 0;
            for (int p = 0; p < NP; p++) prevRegion[p] = 0;
        end else begin
            free = DEPTH - mdlQ.size();
            acc  = 0;
            nRom = 0;
            if (mdlQ.size() > 0 && dport_ready) tmp = mdlQ.pop_front();
            for (int p = 0; p < NP; p++) begin
                a = addr[p*16 +: 16];
                if (we[p] && a == 16'h4000) begin
                    if (acc < free) begin
                        mdlQ.push_back(wdata[p*8 +: 8]);
                        acc++;
                    end else begin
                        mdlOvf = 1;
                    end
                end
                if (we[p] && a == 16'h4100) mdlDone[p] = 1'b1;
                if (we[p] && region(a) == 2) nRom++;
                prevRegion[p] = region(a);
            end
            mdlErr = (mdlErr + nRom > 255) ? 255 : mdlErr + nRom;
        end
        @(posedge clk);
        #1;
        ram_rdata = 16'($urandom);
        rom_rdata = 16'($urandom);
        #1;
        for (int p = 0; p < NP; p++) begin
            expRdata[p] = (prevRegion[p] == 1) ? ram_rdata[p*8 +: 8] :
                          (prevRegion[p] == 2) ? rom_rdata[p*8 +: 8] : 8'h00;
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        we = '0; addr = '0; wdata = '0; dport_ready = 1'b0;
        ram_rdata = 16'hFFFF; rom_rdata = 16'hFFFF;
        doReset();
        checks++; if (dport_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", dport_valid); end
        checks++; if (dport_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_data got=%h exp=00", dport_data); end
        checks++; if (dport_overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf got=%b exp=0", dport_overflow); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        checks++; if (err_count !== 8'h00) begin failures++; $display("[TB] FAIL reset_err got=%h exp=00", err_count); end
        checks++; if (rdata !== 16'h0000) begin failures++; $display("[TB] FAIL reset_rdata got=%h exp=0000", rdata); end
    endtask

    task automatic test_reads();
        addr = {16'hFFFC, 16'h0010}; we = '0;
        #1;
        checks++; if (ram_addr[13:0] !== 14'h0010) begin failures++; $display("[TB] FAIL ram_addr got=%h exp=0010", ram_addr[13:0]); end
        checks++; if (rom_addr[29:15] !== 15'h7FFC) begin failures++; $display("[TB] FAIL rom_addr got=%h exp=7ffc", rom_addr[29:15]); end
        step();
        checks++; if (rdata[7:0] !== ram_rdata[7:0]) begin failures++; $display("[TB] FAIL read_ram got=%h exp=%h", rdata[7:0], ram_rdata[7:0]); end
        checks++; if (rdata[15:8] !== rom_rdata[15:8]) begin failures++; $display("[TB] FAIL read_rom got=%h exp=%h", rdata[15:8], rom_rdata[15:8]); end
        addr = {16'h4000, 16'h4000};
        step();
        checks++; if (rdata !== 16'h0000) begin failures++; $display("[TB] FAIL read_io got=%h exp=0000", rdata); end
    endtask

    task automatic test_debug_pair();
        doReset();
        dport_ready = 1'b1;
        addr = {16'h4000, 16'h4000}; wdata = 16'h2211; we = 2'b11;
        step();
        we = '0; addr = '0;
        checks++; if (dport_valid !== 1'b1 || dport_data !== 8'h11) begin failures++; $display("[TB] FAIL dbg_first got=%b/%h exp=1/11", dport_valid, dport_data); end
        step();
        checks++; if (dport_valid !== 1'b1 || dport_data !== 8'h22) begin failures++; $display("[TB] FAIL dbg_second got=%b/%h exp=1/22", dport_valid, dport_data); end
        step();
        checks++; if (dport_valid !== 1'b0) begin failures++; $display("[TB] FAIL dbg_empty got=%b exp=0", dport_valid); end
    endtask

    task automatic test_overflow();
        doReset();
        dport_ready = 1'b0;
        addr = {16'h0000, 16'h4000}; we = 2'b01;
        for (int i = 0; i < 7; i++) begin
            wdata = {8'h00, 8'(i + 1)};
            step();
        end
        checks++; if (dport_overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_early got=%b exp=0", dport_overflow); end
        addr = {16'h4000, 16'h4000}; wdata = 16'hB0A0; we = 2'b11;
        step();
        checks++; if (dport_overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_set got=%b exp=1", dport_overflow); end
        checks++; if (dport_data !== 8'h01) begin failures++; $display("[TB] FAIL ovf_head got=%h exp=01", dport_data); end
        dport_ready = 1'b1; addr = {16'h0000, 16'h4000}; wdata = 16'h00CC; we = 2'b01;
        step();
        we = '0; addr = '0;
        checks++; if (dport_overflow !== 1'b1 || dport_data !== 8'h02) begin failures++; $display("[TB] FAIL full_pop got=%b/%h exp=1/02", dport_overflow, dport_data); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dport_valid !== (mdlQ.size() > 0) || dport_data !== (mdlQ.size() > 0 ? mdlQ[0] : 8'h00)) begin
                failures++;
                $display("[TB] FAIL drain%0d got=%b/%h exp=%b/%h", i, dport_valid, dport_data, mdlQ.size() > 0, mdlQ.size() > 0 ? mdlQ[0] : 8'h00);
            end
            step();
        end
        checks++; if (dport_valid !== 1'b0) begin failures++; $display("[TB] FAIL drain_end got=%b exp=0", dport_valid); end
    endtask

    task automatic test_done();
        doReset();
        for (int c = 0; c < 12; c++) begin
            we   = {c == 9, c == 5};
            addr = {16'h4100, 16'h4100};
            step();
            checks++;
            if (done !== (c >= 9)) begin failures++; $display("[TB] FAIL done_c%0d got=%b exp=%b", c, done, c >= 9); end
        end
        we = '0;
        doReset();
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL done_rst got=%b exp=0", done); end
    endtask

    task automatic test_err_saturation();
        doReset();
        addr = {16'h8000, 16'h8000}; we = 2'b11; wdata = 16'h5A5A;
        for (int c = 0; c < 200; c++) begin
            checks++; if (ram_we !== 2'b00) begin failures++; $display("[TB] FAIL rom_ramwe got=%b exp=00", ram_we); end
            step();
            checks++; if (err_count !== 8'(mdlErr)) begin failures++; $display("[TB] FAIL err_c%0d got=%0d exp=%0d", c, err_count, mdlErr); end
        end
        we = '0;
        checks++; if (err_count !== 8'd255) begin failures++; $display("[TB] FAIL err_sat got=%0d exp=255", err_count); end
    endtask

    task automatic test_random();
        logic [15:0] a;
        doReset();
        for (int c = 0; c < 300; c++) begin
            for (int p = 0; p < NP; p++) begin
                case ($urandom_range(0, 4))
                    0: a = 16'($urandom_range(0, 16383));
                    1: a = 16'($urandom_range(32768, 65535));
                    2: a = 16'h4000;
                    3: a = 16'h4100;
                    default: a = 16'($urandom);
                endcase
                addr[p*16 +: 16] = a;
            end
            we          = 2'($urandom);
            wdata       = 16'($urandom);
            dport_ready = ($urandom_range(0, 3) != 0);
            rst         = (c == 150);
            #1;
            checks++; if (ram_we !== expRamWe()) begin failures++; $display("[TB] FAIL rnd_ramwe c%0d got=%b exp=%b", c, ram_we, expRamWe()); end
            checks++; if (ram_wdata !== wdata) begin failures++; $display("[TB] FAIL rnd_wdata c%0d got=%h exp=%h", c, ram_wdata, wdata); end
            step();
            checks++;
            if (dport_valid !== (mdlQ.size() > 0) || dport_data !== (mdlQ.size() > 0 ? mdlQ[0] : 8'h00)) begin
                failures++;
                $display("[TB] FAIL rnd_fifo c%0d got=%b/%h exp=%b/%h", c, dport_valid, dport_data, mdlQ.size() > 0, mdlQ.size() > 0 ? mdlQ[0] : 8'h00);
            end
            checks++; if (dport_overflow !== mdlOvf) begin failures++; $display("[TB] FAIL rnd_ovf c%0d got=%b exp=%b", c, dport_overflow, mdlOvf); end
            checks++; if (done !== (&mdlDone)) begin failures++; $display("[TB] FAIL rnd_done c%0d got=%b exp=%b", c, done, &mdlDone); end
            checks++; if (err_count !== 8'(mdlErr)) begin failures++; $display("[TB] FAIL rnd_err c%0d got=%0d exp=%0d", c, err_count, mdlErr); end
            checks++; if (rdata !== {expRdata[1], expRdata[0]}) begin failures++; $display("[TB] FAIL rnd_rdata c%0d got=%h exp=%h", c, rdata, {expRdata[1], expRdata[0]}); end
        end
        rst = 1'b0;
        we  = '0;
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_reads();
        test_debug_pair();
        test_overflow();
        test_done();
        test_err_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
